// File: rtl/lookahead_adder_66_if.sv
// Operand/result bundle for the 66-bit lookahead adder.
// Latency: none; this is only a grouping of wires.
// Backpressure: none; the adder accepts a new operand pair every cycle.
interface lookahead_adder_66_if;
    logic [65:0] A;
    logic [65:0] B;
    logic [65:0] S;
    logic        c66;

    // Producer of operands, consumer of the sum
    modport master (output A, output B, input S, input c66);
    // The adder itself
    modport slave  (input A, input B, output S, output c66);
endinterface

// File: rtl/lookahead_adder_66.sv
// 66-bit three-level carry-lookahead adder: {c66, S} = A + B, no carry-in.
// Latency: 0 cycles by default; 1 cycle when ADDER66_OUTREG_EN is defined.
// Backpressure: none; a new operand pair may be presented every cycle.
module lookahead_adder_66 (
    input  logic                   clk,
    input  logic                   rstn,
    lookahead_adder_66_if.slave    bus
);

    // Group generate over four (p,g) pairs: G = g3 | p3g2 | p3p2g1 | p3p2p1g0
    function automatic logic grp_g(input logic [3:0] p, input logic [3:0] g);
        grp_g = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Group propagate: every position passes an incoming carry
    function automatic logic grp_p(input logic [3:0] p);
        grp_p = &p;
    endfunction

    // Flattened two-level carries c1..c3 of a 4-wide group from its carry-in
    function automatic logic [2:0] grp_carry(input logic [3:0] p,
                                             input logic [3:0] g,
                                             input logic       cin);
        logic c1, c2, c3;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);
        grp_carry = {c3, c2, c1};
    endfunction

    logic [65:0] w_p;           // bit propagate
    logic [65:0] w_g;           // bit generate
    logic [65:0] w_c;           // carry into each bit
    logic [65:0] w_sum;
    logic        w_c66;

    logic [15:0] w_blk_p;       // level-1 group propagate (4-bit blocks)
    logic [15:0] w_blk_g;       // level-1 group generate
    logic [15:0] w_blk_cin;     // carry into each 4-bit block
    logic [3:0]  w_sec_p;       // level-2 section propagate (16-bit sections)
    logic [3:0]  w_sec_g;       // level-2 section generate
    logic [3:0]  w_sec_cin;     // carry into each section (c0, c16, c32, c48)
    logic        w_c64;         // level-3 carry into the top 2-bit block

    assign w_p = bus.A ^ bus.B;
    assign w_g = bus.A & bus.B;

    // Level 1: sixteen 4-bit CLA blocks covering bits 0..63
    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_blk
            assign w_blk_p[k]          = grp_p(w_p[4*k +: 4]);
            assign w_blk_g[k]          = grp_g(w_p[4*k +: 4], w_g[4*k +: 4]);
            assign w_c[4*k]            = w_blk_cin[k];
            assign w_c[4*k+3 : 4*k+1]  = grp_carry(w_p[4*k +: 4], w_g[4*k +: 4],
                                                   w_blk_cin[k]);
        end
    endgenerate

    // Level 2: four lookahead units, each spanning four blocks
    genvar s;
    generate
        for (s = 0; s < 4; s++) begin : g_sec
            assign w_sec_p[s]                 = grp_p(w_blk_p[4*s +: 4]);
            assign w_sec_g[s]                 = grp_g(w_blk_p[4*s +: 4],
                                                      w_blk_g[4*s +: 4]);
            assign w_blk_cin[4*s]             = w_sec_cin[s];
            assign w_blk_cin[4*s+3 : 4*s+1]   = grp_carry(w_blk_p[4*s +: 4],
                                                          w_blk_g[4*s +: 4],
                                                          w_sec_cin[s]);
        end
    endgenerate

    // Level 3: one lookahead unit over the sections; the adder has no carry-in
    assign w_sec_cin[0]   = 1'b0;
    assign w_sec_cin[3:1] = grp_carry(w_sec_p, w_sec_g, 1'b0);
    assign w_c64          = grp_g(w_sec_p, w_sec_g);

    // Top 2-bit block (bits 64..65) hanging off c64
    assign w_c[64] = w_c64;
    assign w_c[65] = w_g[64] | (w_p[64] & w_c64);
    assign w_c66   = w_g[65] | (w_p[65] & w_g[64]) | (w_p[65] & w_p[64] & w_c64);

    assign w_sum = w_p ^ w_c;

`ifdef ADDER66_OUTREG_EN
    logic [65:0] r_sum;
    logic        r_c66;

    // Output register: async clear to zero, loads the CLA result every edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
            r_c66 <= 1'b0;
        end else begin
            r_sum <= w_sum;
            r_c66 <= w_c66;
        end
    end

    assign bus.S   = r_sum;
    assign bus.c66 = r_c66;
`else
    // Clock and reset only matter for the registered build
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rstn;

    assign bus.S   = w_sum;
    assign bus.c66 = w_c66;
`endif

endmodule

// File: tb/tb_lookahead_adder_66.sv
// Bench for lookahead_adder_66: directed corner vectors plus random pairs
// against an arithmetic reference. Works for both the combinational and the
// ADDER66_OUTREG_EN builds by sampling one edge after driving.
module tb_lookahead_adder_66;

    logic clk;
    logic rstn;
    lookahead_adder_66_if bus ();

    lookahead_adder_66 dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got c66=%0b S=%h, expected c66=%0b S=%h",
                     tag, obs[66], obs[65:0], exp[66], exp[65:0]);
        end
    endtask

    // Reference: plain 67-bit unsigned addition
    function automatic logic [66:0] ref_add(input logic [65:0] a, input logic [65:0] b);
        logic [66:0] wa, wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        ref_add = wa + wb;
    endfunction

    // Drive at negedge, sample 1 time unit after the following posedge
    task automatic apply(input logic [65:0] a, input logic [65:0] b);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [65:0] a, input logic [65:0] b,
                           input logic [65:0] exp_s, input logic exp_c);
        apply(a, b);
        chk(tag, {bus.c66, bus.S}, {exp_c, exp_s});
    endtask

    function automatic logic [65:0] rnd66();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        rnd66 = r[65:0];
    endfunction

    initial begin
        logic [65:0] a, b;
        logic [65:0] neg5, neg1;
        neg5 = ~66'd5 + 66'd1;
        neg1 = '1;

        // Reset state with zero operands
        rstn  = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #12;
        chk("reset", {bus.c66, bus.S}, 67'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_vec("zero",       66'd0, 66'd0, 66'd0, 1'b0);
        run_vec("full_prop",  66'h3_FFFF_FFFF_FFFF_FFFF, 66'd1, 66'd0, 1'b1);
        run_vec("all_p",      66'h2_AAAA_AAAA_AAAA_AAAA, 66'h1_5555_5555_5555_5555,
                              66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0);
        run_vec("blk_bound",  66'hF, 66'd1, 66'h10, 1'b0);
        run_vec("sec_bound",  66'hFFFF, 66'd1, 66'h1_0000, 1'b0);
        run_vec("c64_bound",  66'h0_FFFF_FFFF_FFFF_FFFF, 66'd1,
                              66'h1_0000_0000_0000_0000, 1'b0);
        run_vec("c65_bound",  66'h1_FFFF_FFFF_FFFF_FFFF, 66'd1,
                              66'h2_0000_0000_0000_0000, 1'b0);
        run_vec("neg5_plus3", neg5, 66'd3, 66'h3_FFFF_FFFF_FFFF_FFFE, 1'b0);
        run_vec("neg1_neg1",  neg1, neg1, 66'h3_FFFF_FFFF_FFFF_FFFE, 1'b1);
        run_vec("top_gen",    66'h2_0000_0000_0000_0000, 66'h2_0000_0000_0000_0000,
                              66'd0, 1'b1);

        // Single-propagate-chain sweep: (2^k - 1) + 1 crosses every boundary
        for (int k = 1; k <= 66; k++) begin
            logic [66:0] ones;
            ones = (67'd1 << k) - 67'd1;
            a = ones[65:0];
            apply(a, 66'd1);
            chk($sformatf("ripple_%0d", k), {bus.c66, bus.S}, ref_add(a, 66'd1));
        end

        // Random regression
        for (int i = 0; i < 65535; i++) begin
            a = rnd66();
            b = rnd66();
            if (i % 8 == 1) b = ~a ^ (66'd1 << $urandom_range(65, 0));
            apply(a, b);
            if (({bus.c66, bus.S} !== ref_add(a, b)) || (i % 4096 == 0))
                chk($sformatf("rand_%0d", i), {bus.c66, bus.S}, ref_add(a, b));
        end

`ifdef ADDER66_OUTREG_EN
        // Registered build: output holds until the edge, then async reset clears it
        @(negedge clk);
        bus.A = 66'h1234;
        bus.B = 66'h1;
        #1;
        chk("hold_before_edge", {bus.c66, bus.S}, ref_add(a, b));
        @(posedge clk);
        #1;
        chk("after_edge", {bus.c66, bus.S}, 67'h1235);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset", {bus.c66, bus.S}, 67'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_vec("post_reset", 66'h3_FFFF_FFFF_FFFF_FFFF, 66'd1, 66'd0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lookahead_adder_66.md
# lookahead_adder_66

Combinational 66-bit two-operand adder built as a hierarchical carry-lookahead structure, producing a 66-bit sum and a carry-out. It serves as the final carry-propagate adder stage of the Booth multiplier datapath, summing the reduced partial-product vectors. An optional output register stage can be compiled in; by default the path is purely combinational.

## Interface

Parameters: none. Width is fixed at 66.

- clk  input  1  clock; used only when the output register is compiled in.
- rstn  input  1  reset, asynchronous, active-low; used only when the output register is compiled in.
- A  input  66  operand A, two's-complement or unsigned bit pattern.
- B  input  66  operand B, same encoding as A.
- S  output  66  sum, (A + B) mod 2^66.
- c66  output  1  carry out of bit 65 (unsigned carry), not signed overflow.

## Operation

- Function: {c66, S} = A + B as a 67-bit unsigned sum. There is no carry-in (carry-in to bit 0 is constant 0).
- Signed interpretation: S is the correct two's-complement sum whenever no signed overflow occurs. No overflow flag is provided.
- Bit level: p_i = A_i ^ B_i, g_i = A_i & B_i, and S_i = p_i ^ c_i.
- Level 1: 16 four-bit CLA blocks cover bits 0..63. Each block produces its internal carries, a group propagate P = &p and a group generate G.
- Level 2: four lookahead units each combine 4 blocks (16 bits). They produce the block carry-ins and the section P/G.
- Level 3: one lookahead unit combines the 4 sections and produces c16, c32, c48, and c64.
- Bits 64..65 form a 2-bit CLA block driven by c64. Its carry-out is c66.
- The carry chain must not be a 66-stage ripple. The behavioural `+` operator is not permitted for the sum/carry path.
- Outputs are defined for all input bit patterns. X/Z on inputs need no defined behaviour.

## Timing

- Default build: fully combinational. S and c66 settle within one clock period of an input change, with no latency and no state.
- Default build: clk and rstn are present but unused.
- Critical path: bit 0 generate → level-3 lookahead → bit-65 sum. The depth must be logarithmic, not linear.
- With the output register compiled in, S and c66 are registered on the posedge of clk, giving 1-cycle latency.
- With the output register compiled in, asserting rstn low sets S = 0 and c66 = 0 immediately, independent of clk.
- Registers load on the first posedge after rstn deasserts. Reset mid-stream discards the in-flight result.

## Configuration

- Macro: ADDER66_OUTREG_EN.
- Undefined (default): combinational outputs, as described above.
- Defined: S and c66 are flopped with asynchronous active-low reset to 0 and 1-cycle latency. The combinational CLA core is unchanged.

## Test plan

- Zero operands: A=0, B=0 → S=0, c66=0.
- Full carry propagation: A=0x3_FFFF_FFFF_FFFF_FFFF, B=1 → S=0, c66=1. Exercises every lookahead level.
- All propagate, no generate: A=0x2_AAAA_AAAA_AAAA_AAAA, B=0x1_5555_5555_5555_5555 → S=0x3_FFFF_FFFF_FFFF_FFFF, c66=0.
- Group and section boundaries: A=0xF, B=1 → S=0x10, and A=0xFFFF_FFFF_FFFF_FFFF, B=1 → S=0x1_0000_0000_0000_0000, c66=0 in both cases.
- Signed values: A=-5, B=3 → S=0x3_FFFF_FFFF_FFFF_FFFE (-2), c66=0. A=-1, B=-1 → S=0x3_FFFF_FFFF_FFFF_FFFE, c66=1.
- Random regression: 65535 random pairs, each S checked against (A+B) mod 2^66 with zero mismatches.
- Registered build (ADDER66_OUTREG_EN defined): with rstn low, S=0 and c66=0. After release, inputs applied before edge n appear at S after edge n.
